// File: rtl/tagged_memory_if.sv
// tagged_memory_if: CPU bus bundle between the micro-BESM core and the tagged main memory.
interface tagged_memory_if #(
   parameter int DW = 64,
   parameter int TW = 8
);
   logic [DW-1:0] i_ad;
   logic [TW-1:0] i_tag;
   logic          i_astb;
   logic          i_atomic;
   logic          i_rd;
   logic          i_wr;
   logic          i_wforce;
   logic [DW-1:0] o_data;
   logic [TW-1:0] o_tag;
   modport master (
      output i_ad, i_tag, i_astb, i_atomic, i_rd, i_wr, i_wforce,
      input  o_data, o_tag
   );
   modport slave (
      input  i_ad, i_tag, i_astb, i_atomic, i_rd, i_wr, i_wforce,
      output o_data, o_tag
   );
endinterface

// File: rtl/tagged_memory.sv
// tagged_memory: word-addressed data+tag memory with tag-bit write protection and atomic address hold.
module tagged_memory #(
   parameter int AW       = 20,
   parameter int DW       = 64,
   parameter int TW       = 8,
   parameter int PROT_BIT = 7
) (
   input logic            clk,
   input logic            reset,
   tagged_memory_if.slave bus
);
   logic [TW+DW-1:0] mem [2**AW];
   logic [AW-1:0]    waddr;
   logic [AW-1:0]    waddr_d;
   logic [AW-1:0]    ea;
   logic [TW+DW-1:0] cur;
   logic             hold_q;
   logic             hold_d;
   logic             bypass;
   logic             wr_en;
   // While an atomic cycle holds, the strobe is ignored so the write-back hits the word that was read.
   always_comb begin
      bypass  = bus.i_astb && !hold_q;
      ea      = bypass ? bus.i_ad[AW-1:0] : waddr;
      cur     = mem[ea];
      wr_en   = bus.i_wr && (bus.i_wforce || !cur[DW+PROT_BIT]);
      waddr_d = bypass ? bus.i_ad[AW-1:0] : waddr;
      hold_d  = bus.i_atomic;
   end
   assign bus.o_data = bus.i_rd ? cur[DW-1:0] : '0;
   assign bus.o_tag  = bus.i_rd ? cur[TW+DW-1:DW] : '0;
   always_ff @(posedge clk) begin
      if (reset) begin
         waddr  <= '0;
         hold_q <= 1'b0;
      end else begin
         waddr  <= waddr_d;
         hold_q <= hold_d;
      end
      if (wr_en) mem[ea] <= {bus.i_tag, bus.i_ad};
   end
endmodule

// File: tb/tb_tagged_memory.sv
// tb_tagged_memory: directed and randomized checks of tagged_memory against a sparse-array model.
module tb_tagged_memory;
   localparam int AW = 20;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   tagged_memory_if #(.DW(64), .TW(8)) bus();
   tagged_memory #(.AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));
   int total = 0;
   int bad = 0;
   bit en = 1'b0;
   logic [71:0] m [int unsigned];
   int unsigned mw = 0;
   bit mhold = 1'b0;
   function automatic logic [71:0] mget(input int unsigned a);
      return m.exists(a) ? m[a] : 72'h0;
   endfunction
   function automatic int unsigned mea();
      return (bus.i_astb && !mhold) ? 32'(bus.i_ad % (64'd1 << AW)) : mw;
   endfunction
   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] b);
      total++;
      if (a !== b) begin
         bad++;
         $display("FAIL %s got=%h want=%h", n, a, b);
      end
   endtask
   always @(posedge clk) begin
      int unsigned a;
      logic [71:0] old;
      a = mea();
      old = mget(a);
      if (bus.i_wr && (bus.i_wforce || !old[71])) m[a] = {bus.i_tag, bus.i_ad};
      if (reset) mw = 0;
      else if (bus.i_astb && !mhold) mw = a;
      mhold = !reset && bus.i_atomic;
   end
   always @(negedge clk) begin
      logic [71:0] e;
      if (en) begin
         e = bus.i_rd ? mget(mea()) : 72'h0;
         chk("o_data", bus.o_data, e[63:0]);
         chk("o_tag", 64'(bus.o_tag), 64'(e[71:64]));
         chk("waddr", 64'(dut.waddr), 64'(mw));
      end
   end
   task automatic go(input logic astb, input logic [63:0] ad, input logic [7:0] tag,
                     input logic atomic, input logic rd, input logic wr, input logic wforce);
      bus.i_astb = astb;
      bus.i_ad = ad;
      bus.i_tag = tag;
      bus.i_atomic = atomic;
      bus.i_rd = rd;
      bus.i_wr = wr;
      bus.i_wforce = wforce;
      @(negedge clk);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      reset = 1'b1;
      go(0, 0, 0, 0, 0, 0, 0); tick();
      en = 1'b1;
      reset = 1'b0;
      go(0, 0, 0, 0, 0, 0, 0);
      chk("rst waddr", 64'(dut.waddr), 64'h0);
      chk("rst data", bus.o_data, 64'h0);
      tick();
      go(1, 64'h12345, 0, 0, 0, 0, 0); tick();
      go(0, 64'hDEADBEEF01234567, 8'h35, 0, 0, 1, 0); tick();
      go(0, 0, 0, 0, 1, 0, 0);
      chk("t1 data", bus.o_data, 64'hDEADBEEF01234567);
      chk("t1 tag", 64'(bus.o_tag), 64'h35);
      chk("t1 waddr", 64'(dut.waddr), 64'h12345);
      tick();
      go(1, 64'h100, 0, 0, 0, 0, 0); tick();
      go(0, 64'hCAFE, 8'h80, 0, 0, 1, 1); tick();
      go(0, 64'h1, 8'h00, 0, 0, 1, 0); tick();
      go(0, 0, 0, 0, 1, 0, 0);
      chk("t2 kept data", bus.o_data, 64'hCAFE);
      chk("t2 kept tag", 64'(bus.o_tag), 64'h80);
      tick();
      go(0, 64'h1, 8'h00, 0, 0, 1, 1); tick();
      go(0, 0, 0, 0, 1, 0, 0);
      chk("t2 force data", bus.o_data, 64'h1);
      chk("t2 force tag", 64'(bus.o_tag), 64'h0);
      tick();
      go(1, 64'h1FFFFF0, 0, 0, 0, 0, 0); tick();
      go(0, 64'h5555, 8'h11, 0, 0, 1, 1); tick();
      go(0, 0, 0, 0, 1, 0, 0);
      chk("t3 waddr", 64'(dut.waddr), 64'hFFFF0);
      chk("t3 data", bus.o_data, 64'h5555);
      chk("t3 tag", 64'(bus.o_tag), 64'h11);
      tick();
      go(1, 64'h9, 0, 0, 0, 0, 0); tick();
      go(0, 64'h99, 0, 0, 0, 1, 1); tick();
      go(1, 64'h5, 0, 0, 0, 0, 0); tick();
      go(0, 0, 0, 1, 1, 0, 0); tick();
      go(1, 64'h9, 0, 1, 0, 0, 0); tick();
      go(0, 64'h77, 0, 1, 0, 1, 0); tick();
      go(0, 0, 0, 0, 1, 0, 0);
      chk("t4 waddr", 64'(dut.waddr), 64'h5);
      chk("t4 mem5", bus.o_data, 64'h77);
      tick();
      go(1, 64'h9, 0, 0, 1, 0, 0);
      chk("t4 mem9", bus.o_data, 64'h99);
      tick();
      go(0, 0, 0, 0, 0, 0, 0);
      chk("t5 rd0 data", bus.o_data, 64'h0);
      chk("t5 rd0 tag", 64'(bus.o_tag), 64'h0);
      tick();
      go(1, 64'h7, 0, 0, 0, 0, 0); tick();
      go(0, 64'hA, 8'h01, 0, 0, 1, 1); tick();
      go(0, 64'hB, 8'h02, 0, 1, 1, 0);
      chk("t5 old", bus.o_data, 64'hA);
      tick();
      go(0, 0, 0, 0, 1, 0, 0);
      chk("t5 new data", bus.o_data, 64'hB);
      chk("t5 new tag", 64'(bus.o_tag), 64'h2);
      tick();
      go(1, 64'h3, 0, 0, 0, 0, 0); tick();
      go(0, 64'hAB, 0, 0, 0, 1, 1); tick();
      reset = 1'b1;
      go(0, 0, 0, 0, 0, 0, 0); tick();
      reset = 1'b0;
      go(0, 0, 0, 0, 0, 0, 0);
      chk("t6 waddr", 64'(dut.waddr), 64'h0);
      tick();
      go(1, 64'h3, 0, 0, 1, 0, 0);
      chk("t6 mem3", bus.o_data, 64'hAB);
      tick();
      for (int i = 0; i < 3000; i++) begin
         int unsigned pool;
         logic [63:0] r;
         logic astb;
         pool = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : 32'hFFFF0 + $urandom_range(0, 15);
         r = {$urandom, $urandom};
         astb = ($urandom_range(0, 3) == 0);
         if (astb) r[19:0] = pool[19:0];
         reset = ($urandom_range(0, 99) == 0);
         go(astb, r, 8'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) < 4, $urandom_range(0, 4) == 0);
         tick();
      end
      reset = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
